// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one down-counting delay timer among NREQ requesters.
// The owner holds grant for len COUNT cycles plus one DONE cycle carrying its done pulse.
module delay_timer_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   len,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [CW-1:0]        count
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [NREQ-1:0] grant_n, done_n, win_onehot;
    logic [CW-1:0]   count_n, win_len;
    logic [PW-1:0]   win;
    logic            found;

    // First requesting index at or after ptr, scanning upward modulo NREQ.
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] idx_p;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_p = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_p = PW'(idx);
            if (!found && req[idx_p]) begin
                found = 1'b1;
                win   = idx_p;
            end
        end
        win_len    = len[32'(win)*CW +: CW];
        win_onehot = NREQ'(1) << win;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant;
        done_n  = '0;
        count_n = count;
        case (state)
            IDLE: begin
                grant_n = '0;
                count_n = '0;
                if (found) begin
                    grant_n = win_onehot;
                    count_n = win_len;
                    ptr_n   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    if (win_len != '0) begin
                        state_n = COUNT;
                    end else begin
                        state_n = DONE;
                        done_n  = win_onehot;
                    end
                end
            end
            COUNT: begin
                // Owner withdrawing its request aborts silently.
                if (!(|(req & grant))) begin
                    state_n = IDLE;
                    grant_n = '0;
                    count_n = '0;
                end else if (count <= CW'(1)) begin
                    state_n = DONE;
                    count_n = '0;
                    done_n  = grant;
                end else begin
                    count_n = count - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                count_n = '0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            grant <= grant_n;
            done  <= done_n;
            busy  <= |grant_n;
            count <= count_n;
        end
    end

endmodule
